alu_shift_seq: RTL
==================

ALU_SHIFT_SEQ -- requirements
Module: alu_shift_seq

Interface
REQ-001 SHALL have parameter OP_ADD, default 3'd0: ALU op driven when not shifting.
REQ-002 SHALL have parameter OP_LSHF, default 3'd4: ALU 1-bit left-shift op.
REQ-003 SHALL have parameter OP_RSHF, default 3'd5: ALU 1-bit logical right-shift op.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: request a shift; sampled only in IDLE.
REQ-007 SHALL have port mode, input, 2: 00 LSHF, 01 RSHFL, 11 RSHFA, 10 treated as LSHF.
REQ-008 SHALL have port operand, input, 16: value to shift.
REQ-009 SHALL have port amount, input, 4: shift count 0..15.
REQ-010 SHALL have port busy, output, 1: high in SHIFT and DONE.
REQ-011 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port result, output, 16: shifted value, held until next completion.
REQ-013 SHALL have ports zero and negative, outputs, 1 each: flags of result.
REQ-014 SHALL have port alu_in1, output, 16: ALU operand A.
REQ-015 SHALL have port alu_in2, output, 16: ALU operand B, constant 16'h0000.
REQ-016 SHALL have port alu_op, output, 3: ALU op select.
REQ-017 SHALL have port alu_out, input, 16: ALU result, combinational from alu_in1/alu_op.

Function
REQ-018 SHALL implement states IDLE, SHIFT, DONE.
REQ-019 IDLE with start=1: SHALL latch operand into acc, amount into cnt, mode, sign=operand[15]; go SHIFT if amount!=0, else DONE.
REQ-020 IDLE with start=0: SHALL remain IDLE.
REQ-021 SHIFT: SHALL drive alu_in1=acc, alu_op=OP_LSHF for LSHF/10, else OP_RSHF.
REQ-022 SHIFT: SHALL load acc<=alu_out each cycle; for RSHFA bit 15 SHALL be forced to latched sign.
REQ-023 SHIFT: SHALL decrement cnt each cycle; when cnt==1 next state DONE.
REQ-024 On entry to DONE SHALL load result, zero=(value==0), negative=value[15]; amount 0 yields result=operand.
REQ-025 DONE: done=1 for exactly that cycle; next state IDLE unconditionally.
REQ-026 Latency: start sampled at edge t; done high in cycle t+amount+1 (amount 0 -> t+1).
REQ-027 start while busy SHALL be ignored; no queuing.
REQ-028 Outside SHIFT SHALL drive alu_in1=16'h0000, alu_op=OP_ADD.
REQ-029 result/zero/negative SHALL change only on DONE entry or reset.

Reset
REQ-030 rst=1 at an edge SHALL force IDLE from any state, including mid-SHIFT and DONE.
REQ-031 After reset: busy=0, done=0, result=0, zero=1, negative=0, acc=0, cnt=0.
REQ-032 rst SHALL take priority over start in the same cycle.

Structure
REQ-033 ALU op codes, mode encodings and state encodings SHALL live in the shared ALU defines header.
REQ-034 One sub-module SHALL be used: shf_count, a 4-bit loadable down-counter with ==1 terminal flag.
REQ-035 The block SHALL contain no ALU logic; all shifting SHALL go through alu_out.

Verification
REQ-036 0x0001, LSHF, amount 4 -> done at t+5, result 0x0010, zero 0, negative 0.
REQ-037 0x8000, RSHFA, amount 15 -> result 0xFFFF, negative 1; RSHFL same input -> 0x0001.
REQ-038 0x4000, LSHF, amount 2 -> result 0x0000, zero 1.
REQ-039 0x0000, amount 0 -> done at t+1, result 0x0000, zero 1; alu_op stays OP_ADD throughout.
REQ-040 start pulsed with new operand during SHIFT -> ignored; first result unaffected.
REQ-041 rst in second SHIFT cycle -> next cycle busy 0, done 0, result 0x0000, zero 1; no done pulse.

Source files
------------

// File: rtl/alu_shift_seq_pkg.sv
// Shared ALU defines for the shift sequencer: ALU op codes, shift-mode
// encodings and sequencer state encodings.
package alu_shift_seq_pkg;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_LSHF = 3'd4;
  localparam logic [2:0] ALU_RSHF = 3'd5;

  typedef enum logic [1:0] {
    MODE_LSHF     = 2'b00,
    MODE_RSHFL    = 2'b01,
    MODE_LSHF_ALT = 2'b10,
    MODE_RSHFA    = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_shift_seq_count.sv
// shf_count: loadable down-counter for the remaining shift steps, with a
// flag marking the last step (count == 1).
module shf_count
  import alu_shift_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             is_one
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign is_one = (cnt == CNT_W'(1));

endmodule

// File: rtl/alu_shift_seq.sv
// Multi-bit shift sequencer: performs an N-bit shift as N single-bit passes
// through an external ALU, then publishes the result with zero/negative flags.
module alu_shift_seq
  import alu_shift_seq_pkg::*;
#(
  parameter logic [2:0] OP_ADD  = ALU_ADD,
  parameter logic [2:0] OP_LSHF = ALU_LSHF,
  parameter logic [2:0] OP_RSHF = ALU_RSHF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] operand,
  input  logic [CNT_W-1:0]  amount,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              negative,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out
);

  state_t            state, state_nxt;
  mode_t             mode_q;
  logic              sign_q;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] shf_val;
  logic [DATA_W-1:0] res_val;
  logic              load_res;
  logic              cnt_load, cnt_dec, cnt_one;
  logic              shift_left;

  shf_count u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (amount),
    .dec      (cnt_dec),
    .is_one   (cnt_one)
  );

  // The ALU only shifts logically; arithmetic right shift re-inserts the sign.
  assign shift_left = (mode_q == MODE_LSHF) || (mode_q == MODE_LSHF_ALT);
  assign shf_val    = (mode_q == MODE_RSHFA) ? {sign_q, alu_out[DATA_W-2:0]} : alu_out;

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign alu_in2 = '0;

  always_comb begin
    state_nxt = state;
    alu_in1   = '0;
    alu_op    = OP_ADD;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    load_res  = 1'b0;
    res_val   = shf_val;
    case (state)
      ST_IDLE: begin
        if (start) begin
          cnt_load = 1'b1;
          if (amount == '0) begin
            state_nxt = ST_DONE;
            load_res  = 1'b1;
            res_val   = operand;
          end else begin
            state_nxt = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        alu_in1 = acc;
        alu_op  = shift_left ? OP_LSHF : OP_RSHF;
        cnt_dec = 1'b1;
        if (cnt_one) begin
          state_nxt = ST_DONE;
          load_res  = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      mode_q   <= MODE_LSHF;
      sign_q   <= 1'b0;
      acc      <= '0;
      result   <= '0;
      zero     <= 1'b1;
      negative <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start) begin
        acc    <= operand;
        mode_q <= mode_t'(mode);
        sign_q <= operand[DATA_W-1];
      end else if (state == ST_SHIFT) begin
        acc <= shf_val;
      end
      if (load_res) begin
        result   <= res_val;
        zero     <= (res_val == '0);
        negative <= res_val[DATA_W-1];
      end
    end
  end

endmodule
